// File: rtl/result_serializer.sv
// Streams a snapshot of N_ELEM products onto an 8-bit valid/ready bus, LSB first,
// optionally followed by an XOR checksum byte, then pulses done for one cycle.
module result_serializer #(
    parameter int unsigned N_ELEM      = 9,
    parameter int unsigned ELEM_W      = 18,
    parameter bit          CHECKSUM_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [N_ELEM*ELEM_W-1:0]   c_flat,
    input  logic                       out_ready,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned BPE    = (ELEM_W + 7) / 8;
    localparam int unsigned IDX_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int unsigned BYTE_W = (BPE > 1) ? $clog2(BPE) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [N_ELEM*ELEM_W-1:0] snap_q, snap_d;
    logic [IDX_W-1:0]         elem_idx_q, elem_idx_d;
    logic [BYTE_W-1:0]        byte_idx_q, byte_idx_d;
    logic [7:0]               csum_q, csum_d;
    logic                     csum_phase_q, csum_phase_d;

    logic [ELEM_W-1:0]        cur_elem;
    logic [BPE*8-1:0]         cur_padded;
    logic [7:0]               cur_byte;
    logic                     last_byte;
    logic                     last_elem;
    logic                     xfer;

    // Index-compare muxes keep the selection free of variable multiplies.
    always_comb begin
        cur_elem = '0;
        for (int unsigned k = 0; k < N_ELEM; k++) begin
            if (elem_idx_q == IDX_W'(k)) begin
                cur_elem = snap_q[k*ELEM_W +: ELEM_W];
            end
        end
        cur_padded               = '0;
        cur_padded[ELEM_W-1:0]   = cur_elem;
        cur_byte                 = '0;
        for (int unsigned b = 0; b < BPE; b++) begin
            if (byte_idx_q == BYTE_W'(b)) begin
                cur_byte = cur_padded[b*8 +: 8];
            end
        end
    end

    assign last_byte = (byte_idx_q == BYTE_W'(BPE - 1));
    assign last_elem = (elem_idx_q == IDX_W'(N_ELEM - 1));

    assign out_valid = (state_q == S_SEND);
    assign busy      = out_valid;
    assign done      = (state_q == S_FIN);
    assign out_data  = out_valid ? (csum_phase_q ? csum_q : cur_byte) : 8'h00;
    assign xfer      = out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        elem_idx_d   = elem_idx_q;
        byte_idx_d   = byte_idx_q;
        csum_d       = csum_q;
        csum_phase_d = csum_phase_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d       = c_flat;
                    elem_idx_d   = '0;
                    byte_idx_d   = '0;
                    csum_d       = '0;
                    csum_phase_d = 1'b0;
                    state_d      = S_SEND;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    if (csum_phase_q) begin
                        state_d = S_FIN;
                    end else begin
                        csum_d = csum_q ^ cur_byte;
                        if (!last_byte) begin
                            byte_idx_d = byte_idx_q + BYTE_W'(1);
                        end else begin
                            byte_idx_d = '0;
                            if (!last_elem) begin
                                elem_idx_d = elem_idx_q + IDX_W'(1);
                            end else if (CHECKSUM_EN) begin
                                csum_phase_d = 1'b1;
                            end else begin
                                state_d = S_FIN;
                            end
                        end
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            snap_q       <= '0;
            elem_idx_q   <= '0;
            byte_idx_q   <= '0;
            csum_q       <= '0;
            csum_phase_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            elem_idx_q   <= elem_idx_d;
            byte_idx_q   <= byte_idx_d;
            csum_q       <= csum_d;
            csum_phase_q <= csum_phase_d;
        end
    end

endmodule
